// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS memory-access stage.
package mips_mc_pkg;

  // Memory-stage sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Kind of access accepted from the controller.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } kind_e;

  // Opcodes the controller decodes from IR[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // IR contents after reset: all-zero decodes as sll $0,$0,0 (NOP).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Word accesses only: the two byte-offset bits must be clear.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter that flags when an outstanding access has waited
// TIMEOUT cycles without an acknowledge.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic       expired,
  output logic [7:0] count
);

  // Value of the counter during the last permitted wait cycle.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Expiry is flagged during the TIMEOUT-th enabled cycle so the owner can
  // abort on the same edge that would otherwise start cycle TIMEOUT+1.
  assign expired = enable && (cnt_q == LAST);
  assign count   = cnt_q;

  // Next count: clear wins, otherwise count enabled cycles up to expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_fetch_unit.sv
// Memory-access stage for the multicycle controller: accepts one fetch, read
// or write command, runs it against a variable-latency memory and latches the
// result into IR or MDR while holding the controller with busy.
//
// Memory handshake: mem_req rises in ISSUE and stays high, together with
// stable mem_addr/mem_we/mem_wdata, until the clock edge that samples
// mem_ack=1 in WAIT. mem_ack is a single-cycle strobe; mem_rdata is only
// looked at in that same cycle. An ack seen in any other state is ignored.
module mem_fetch_unit
  import mips_mc_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] wdata,
  input  logic          IorD,
  input  logic          IRWrite,
  input  logic          MemRead,
  input  logic          MemWrite,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] instr,
  output logic [5:0]    opcode,
  output logic [DW-1:0] mdr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_e        state_dbg
);

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          err_q, err_d;

  logic          cmd_any;
  logic          cmd_multi;
  kind_e         cmd_kind;
  logic [AW-1:0] sel_addr;
  logic          ctr_clear;
  logic          ctr_enable;
  logic          ctr_expired;
  logic [7:0]    ctr_count;

  // Command decode: address mux and strobe priority IRWrite > MemRead > MemWrite.
  always_comb begin
    sel_addr  = IorD ? alu_out : pc;
    cmd_any   = IRWrite | MemRead | MemWrite;
    cmd_multi = (IRWrite & MemRead) | (IRWrite & MemWrite) | (MemRead & MemWrite);
    cmd_kind  = WRITE;
    if (IRWrite) begin
      cmd_kind = FETCH;
    end else if (MemRead) begin
      cmd_kind = READ;
    end
  end

  // The wait counter only runs while an access is outstanding and unanswered.
  assign ctr_clear  = (state_q != WAIT);
  assign ctr_enable = (state_q == WAIT) && !mem_ack;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expired(ctr_expired),
    .count  (ctr_count)
  );

  // Next-state, command capture and result loading.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    mdr_d   = mdr_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_any) begin
          if (!is_word_aligned(sel_addr[1:0])) begin
            // Rejected without touching memory or the captured command.
            err_d = 1'b1;
          end else begin
            state_d = ISSUE;
            kind_d  = cmd_kind;
            we_d    = (cmd_kind == WRITE);
            addr_d  = sel_addr;
            wdata_d = wdata;
            err_d   = cmd_multi;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = DONE;
          if (kind_q == FETCH) begin
            instr_d = mem_rdata;
          end else if (kind_q == READ) begin
            mdr_d = mem_rdata;
          end
        end else if (ctr_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= DW'(NOP_INSTR);
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  // Memory port: request straight from state so reset drops it at once.
  assign mem_req   = (state_q == ISSUE) || (state_q == WAIT);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Controller-facing outputs.
  assign instr     = instr_q;
  assign opcode    = instr_q[DW-1 -: 6];
  assign mdr       = mdr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed bench for mem_fetch_unit: a vector table of single accesses plus
// hand-written sequences for timeout, reset mid-access and multiple strobes.
module tb_mem_fetch_unit;
  import mips_mc_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc, alu_out, wdata;
  logic        IorD, IRWrite, MemRead, MemWrite;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] instr, mdr;
  logic [5:0]  opcode;
  logic        busy, done, err;
  state_e      state_dbg;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic        irw, mrd, mwr, iord;
    logic [31:0] pc, alu, wd;
    int          delay;      // WAIT cycles without ack before the ack cycle
    logic [31:0] rdata;
    logic        exp_req;    // 0: access rejected before reaching memory
    logic        exp_err;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_instr;
    logic [31:0] exp_mdr;
  } vec_t;

  mem_fetch_unit #(
    .DW(32), .AW(32), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr(instr), .opcode(opcode), .mdr(mdr), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge (driving point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  // Drive one command and play the memory side with the given ack delay.
  task automatic run_txn(input vec_t v);
    step();
    IRWrite = v.irw; MemRead = v.mrd; MemWrite = v.mwr; IorD = v.iord;
    pc = v.pc; alu_out = v.alu; wdata = v.wd;
    step();                       // acceptance edge t passed, now cycle t+1
    IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check({v.name, " err@t+1"}, 32'(err), 32'(v.exp_err));
    check({v.name, " req@t+1"}, 32'(mem_req), 32'(v.exp_req));
    if (!v.exp_req) begin
      check({v.name, " busy@t+1"}, 32'(busy), 32'd0);
      step();
      @(negedge clk);
      check({v.name, " err cleared"}, 32'(err), 32'd0);
      check({v.name, " no req"}, 32'(mem_req), 32'd0);
      check({v.name, " instr kept"}, instr, v.exp_instr);
      check({v.name, " mdr kept"}, mdr, v.exp_mdr);
      return;
    end
    check({v.name, " addr"}, mem_addr, v.exp_addr);
    check({v.name, " we"}, 32'(mem_we), 32'(v.exp_we));
    if (v.exp_we) check({v.name, " wdata"}, mem_wdata, v.wd);
    step();                       // first WAIT cycle
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      check({v.name, " req held"}, 32'(mem_req), 32'd1);
      check({v.name, " addr held"}, mem_addr, v.exp_addr);
      step();
    end
    mem_ack = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    check({v.name, " req at ack"}, 32'(mem_req), 32'd1);
    if (v.exp_we) check({v.name, " wdata at ack"}, mem_wdata, v.wd);
    step();                       // DONE cycle
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check({v.name, " done"}, 32'(done), 32'd1);
    check({v.name, " busy in done"}, 32'(busy), 32'd1);
    check({v.name, " req dropped"}, 32'(mem_req), 32'd0);
    check({v.name, " err in done"}, 32'(err), 32'd0);
    check({v.name, " instr"}, instr, v.exp_instr);
    step();                       // back in IDLE
    @(negedge clk);
    check({v.name, " done low"}, 32'(done), 32'd0);
    check({v.name, " busy low"}, 32'(busy), 32'd0);
    check({v.name, " instr idle"}, instr, v.exp_instr);
    check({v.name, " opcode"}, 32'(opcode), 32'(v.exp_instr[31:26]));
    check({v.name, " mdr"}, mdr, v.exp_mdr);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   req_cycles;
    logic saw_drop;

    checks = 0;
    errors = 0;

    //          name        irw  mrd  mwr  iord pc           alu          wd           dly rdata        req  err  addr         we   instr        mdr
    vecs[0] = '{"fetch40",  1'b1,1'b0,1'b0,1'b0,32'h0000_0040,32'h0,       32'h0,       2, 32'h8C22_0004,1'b1,1'b0,32'h0000_0040,1'b0,32'h8C22_0004,32'h0};
    vecs[1] = '{"read100",  1'b0,1'b1,1'b0,1'b1,32'h0000_0044,32'h0000_0100,32'h0,      0, 32'hDEAD_BEEF,1'b1,1'b0,32'h0000_0100,1'b0,32'h8C22_0004,32'hDEAD_BEEF};
    vecs[2] = '{"write104", 1'b0,1'b0,1'b1,1'b1,32'h0000_0044,32'h0000_0104,32'h1234_5678,3,32'hFFFF_FFFF,1'b1,1'b0,32'h0000_0104,1'b1,32'h8C22_0004,32'hDEAD_BEEF};
    vecs[3] = '{"read102",  1'b0,1'b1,1'b0,1'b1,32'h0000_0044,32'h0000_0102,32'h0,      0, 32'h0,        1'b0,1'b1,32'h0,        1'b0,32'h8C22_0004,32'hDEAD_BEEF};
    vecs[4] = '{"fetch48",  1'b1,1'b0,1'b0,1'b0,32'h0000_0048,32'h0000_0103,32'h0,      1, 32'h1000_0003,1'b1,1'b0,32'h0000_0048,1'b0,32'h1000_0003,32'hDEAD_BEEF};
    vecs[5] = '{"read200",  1'b0,1'b1,1'b0,1'b1,32'h0000_004A,32'h0000_0200,32'h0,      0, 32'hCAFE_F00D,1'b1,1'b0,32'h0000_0200,1'b0,32'h1000_0003,32'hCAFE_F00D};
    vecs[6] = '{"fetch300", 1'b1,1'b0,1'b0,1'b1,32'h0000_0041,32'h0000_0300,32'h0,      4, 32'hAC41_0008,1'b1,1'b0,32'h0000_0300,1'b0,32'hAC41_0008,32'hCAFE_F00D};
    vecs[7] = '{"fetch41",  1'b1,1'b0,1'b0,1'b0,32'h0000_0041,32'h0000_0300,32'h0,      0, 32'h0,        1'b0,1'b1,32'h0,        1'b0,32'hAC41_0008,32'hCAFE_F00D};

    // Reset phase.
    rst_n = 1'b0;
    pc = 32'h0; alu_out = 32'h0; wdata = 32'h0; IorD = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req", 32'(mem_req), 32'd0);
    check("reset we", 32'(mem_we), 32'd0);
    check("reset addr", mem_addr, 32'h0);
    check("reset wdata", mem_wdata, 32'h0);
    check("reset instr", instr, 32'(NOP_INSTR));
    check("reset opcode", 32'(opcode), 32'(OP_RTYPE));
    check("reset mdr", mdr, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset state", 32'(state_dbg), 32'(IDLE));
    step();
    rst_n = 1'b1;

    // Table-driven single accesses.
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    check("lw opcode const", 32'(vecs[0].exp_instr[31:26]), 32'(OP_LW));

    // Timeout: no ack ever; expect TB_TIMEOUT WAIT cycles of mem_req.
    step();
    IRWrite = 1'b1; IorD = 1'b0; pc = 32'h0000_0050;
    step();                       // cycle t+1 (ISSUE)
    IRWrite = 1'b0;
    @(negedge clk);
    check("tmo req issue", 32'(mem_req), 32'd1);
    req_cycles = 0;
    saw_drop = 1'b0;
    for (int i = 0; i < 3 * TB_TIMEOUT && !saw_drop; i++) begin
      step();
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
      end else begin
        saw_drop = 1'b1;
        check("tmo err pulse", 32'(err), 32'd1);
        check("tmo busy", 32'(busy), 32'd0);
        check("tmo done", 32'(done), 32'd0);
      end
    end
    check("tmo dropped", 32'(saw_drop), 32'd1);
    check("tmo wait cycles", 32'(req_cycles), 32'(TB_TIMEOUT));
    check("tmo instr kept", instr, 32'hAC41_0008);
    step();
    @(negedge clk);
    check("tmo err one cycle", 32'(err), 32'd0);
    v = '{"after_tmo", 1'b0,1'b1,1'b0,1'b1,32'h0,32'h0000_0400,32'h0,1,32'h5555_AAAA,
          1'b1,1'b0,32'h0000_0400,1'b0,32'hAC41_0008,32'h5555_AAAA};
    run_txn(v);

    // Reset during WAIT, with a late ack after release.
    step();
    IRWrite = 1'b1; IorD = 1'b0; pc = 32'h0000_0060;
    step();
    IRWrite = 1'b0;
    step();                       // WAIT
    step();                       // still WAIT
    @(negedge clk);
    check("rst pre req", 32'(mem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst req drop", 32'(mem_req), 32'd0);
    check("rst instr nop", instr, 32'h0);
    check("rst mdr", mdr, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    mem_ack = 1'b1;
    mem_rdata = 32'h8C22_0004;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("late ack instr", instr, 32'h0);
    check("late ack done", 32'(done), 32'd0);
    check("late ack busy", 32'(busy), 32'd0);
    check("late ack req", 32'(mem_req), 32'd0);

    // Fetch and write strobed together: fetch served, err flagged.
    v = '{"multi", 1'b1,1'b0,1'b1,1'b0,32'h0000_0070,32'h0000_0080,32'h9999_9999,0,32'h0022_0820,
          1'b1,1'b1,32'h0000_0070,1'b0,32'h0022_0820,32'h0};
    run_txn(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
